// File: rtl/ldpc_3gpp_enc_frame_arb.sv
// Frame-level round-robin arbiter in front of a fixed-length LDPC encoder input port.
// Grants one requester per frame, prefixes its id to the tag and enforces the frame length.
module ldpc_3gpp_enc_frame_arb #(
  parameter int pN_REQ   = 4,
  parameter int pDAT_W   = 8,
  parameter int pTAG_W   = 4,
  parameter int pFRM_LEN = 22,
  localparam int cID_W   = (pN_REQ > 1) ? $clog2(pN_REQ) : 1
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic [pN_REQ-1:0]          ireq,
  input  logic [pN_REQ-1:0]          isop,
  input  logic [pN_REQ-1:0]          ival,
  input  logic [pN_REQ-1:0]          ieop,
  input  logic [pN_REQ*pDAT_W-1:0]   idat,
  input  logic [pN_REQ*pTAG_W-1:0]   itag,
  output logic [pN_REQ-1:0]          ogrant,
  input  logic                       icore_rdy,
  output logic                       ocore_sop,
  output logic                       ocore_val,
  output logic                       ocore_eop,
  output logic [pDAT_W-1:0]          ocore_dat,
  output logic [cID_W+pTAG_W-1:0]    ocore_tag,
  output logic [1:0]                 oerr
);

  localparam int cCNT_W = (pFRM_LEN > 1) ? $clog2(pFRM_LEN) : 1;
  localparam logic [cCNT_W-1:0] cLAST   = cCNT_W'(pFRM_LEN - 1);
  localparam logic [cID_W-1:0]  cID_MAX = cID_W'(pN_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t             state;
  logic [cID_W-1:0]   rr;
  logic [cID_W-1:0]   sel;
  logic [cCNT_W-1:0]  cnt;

  logic [pDAT_W-1:0]  dat_a [pN_REQ];
  logic [pTAG_W-1:0]  tag_a [pN_REQ];

  for (genvar g = 0; g < pN_REQ; g++) begin : g_lane
    assign dat_a[g] = idat[g*pDAT_W +: pDAT_W];
    assign tag_a[g] = itag[g*pTAG_W +: pTAG_W];
  end

  // round-robin scan: first pending request at or above the rr pointer, modulo pN_REQ
  logic [cID_W-1:0]  nxt_sel;
  logic              nxt_found;
  int unsigned       scan_idx;
  logic [cID_W-1:0]  scan_id;

  always_comb begin
    nxt_sel   = '0;
    nxt_found = 1'b0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int unsigned i = 0; i < pN_REQ; i++) begin
      scan_idx = rr + i;
      if (scan_idx >= pN_REQ)
        scan_idx = scan_idx - pN_REQ;
      scan_id = cID_W'(scan_idx);
      if (!nxt_found && ireq[scan_id]) begin
        nxt_found = 1'b1;
        nxt_sel   = scan_id;
      end
    end
  end

  logic               s_req, s_sop, s_val, s_eop;
  logic [pDAT_W-1:0]  s_dat;
  logic [pTAG_W-1:0]  s_tag;
  logic [cCNT_W-1:0]  widx;
  logic               at_last, take, end_w;

  always_comb begin
    s_req   = ireq[sel];
    s_sop   = isop[sel];
    s_val   = ival[sel];
    s_eop   = ieop[sel];
    s_dat   = dat_a[sel];
    s_tag   = tag_a[sel];
    widx    = (state == GRANT) ? '0 : cnt;
    at_last = (widx == cLAST);
    take    = s_val && (((state == GRANT) && s_sop) || (state == XFER));
    end_w   = s_eop || at_last;
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state     <= IDLE;
      rr        <= '0;
      sel       <= '0;
      cnt       <= '0;
      ogrant    <= '0;
      ocore_sop <= 1'b0;
      ocore_val <= 1'b0;
      ocore_eop <= 1'b0;
      ocore_dat <= '0;
      ocore_tag <= '0;
      oerr      <= '0;
    end else if (iclkena) begin
      ocore_sop <= 1'b0;
      ocore_val <= 1'b0;
      ocore_eop <= 1'b0;
      oerr      <= '0;
      if (take) begin
        ocore_val <= 1'b1;
        ocore_sop <= (state == GRANT);
        ocore_eop <= end_w;
        ocore_dat <= s_dat;
        cnt       <= widx + 1'b1;
        if (state == GRANT)
          ocore_tag <= {sel, s_tag};
        // eop before the last slot is short; a last slot without eop is truncated
        if (s_eop && !at_last)
          oerr <= 2'b01;
        else if (!s_eop && at_last)
          oerr <= 2'b10;
      end
      case (state)
        IDLE: begin
          if (nxt_found && icore_rdy) begin
            sel    <= nxt_sel;
            ogrant <= pN_REQ'(1) << nxt_sel;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (take) begin
            if (end_w) begin
              ogrant <= '0;
              state  <= DONE;
            end else begin
              state  <= XFER;
            end
          end else if (!s_req) begin
            ogrant <= '0;
            state  <= DONE;
          end
        end
        XFER: begin
          if (take && end_w) begin
            ogrant <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          rr    <= (sel == cID_MAX) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_frame_arb.sv
// Directed bench for ldpc_3gpp_enc_frame_arb with pN_REQ=4, pFRM_LEN=8.
module tb_ldpc_3gpp_enc_frame_arb;

  localparam int N  = 4;
  localparam int FL = 8;

  logic        iclk = 1'b0;
  logic        ireset, iclkena, icore_rdy;
  logic [3:0]  ireq, isop, ival, ieop;
  logic [31:0] idat;
  logic [15:0] itag;
  logic [3:0]  ogrant;
  logic        ocore_sop, ocore_val, ocore_eop;
  logic [7:0]  ocore_dat;
  logic [5:0]  ocore_tag;
  logic [1:0]  oerr;

  int checks = 0;
  int errors = 0;

  always #5 iclk = ~iclk;

  ldpc_3gpp_enc_frame_arb #(
    .pN_REQ   (4),
    .pDAT_W   (8),
    .pTAG_W   (4),
    .pFRM_LEN (8)
  ) dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iclkena   (iclkena),
    .ireq      (ireq),
    .isop      (isop),
    .ival      (ival),
    .ieop      (ieop),
    .idat      (idat),
    .itag      (itag),
    .ogrant    (ogrant),
    .icore_rdy (icore_rdy),
    .ocore_sop (ocore_sop),
    .ocore_val (ocore_val),
    .ocore_eop (ocore_eop),
    .ocore_dat (ocore_dat),
    .ocore_tag (ocore_tag),
    .oerr      (oerr)
  );

  // output words: {sop, eop, err[1:0], tag[5:0], dat[7:0]}
  logic [17:0] mon_q[$];
  bit          ena_edge = 1'b0;

  always @(posedge iclk) ena_edge = iclkena;
  always @(negedge iclk)
    if (ena_edge && ocore_val)
      mon_q.push_back({ocore_sop, ocore_eop, oerr, ocore_tag, ocore_dat});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lane(input int n, input logic s, input logic v, input logic e,
                          input logic [7:0] d, input logic [3:0] t);
    isop[n] = s;
    ival[n] = v;
    ieop[n] = e;
    idat[n*8 +: 8] = d;
    itag[n*4 +: 4] = t;
  endtask

  task automatic clear_lanes();
    for (int m = 0; m < N; m++) set_lane(m, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic wait_grant();
    int waitc = 0;
    @(negedge iclk);
    while (ogrant == '0 && waitc < 40) begin
      @(negedge iclk);
      waitc++;
    end
  endtask

  // eop_at: 1-based word carrying ieop (0 = none); pre: junk words ahead of sop
  task automatic run_frame(input int n, input int nwords, input int eop_at, input int pre,
                           input int rdy_drop, input logic [7:0] base, input logic [3:0] tg);
    int          fwd;
    logic [17:0] got, exp;
    logic [1:0]  lerr;
    logic [7:0]  d;
    fwd = (eop_at > 0 && eop_at <= FL) ? eop_at : ((nwords < FL) ? nwords : FL);
    wait_grant();
    check("grant", 32'(ogrant), 32'(1) << n);
    for (int k = 0; k < pre + nwords; k++) begin
      int j = k - pre;
      for (int m = 0; m < N; m++)
        if (m != n) set_lane(m, 1'b1, 1'b1, 1'b1, 8'hEE, 4'hF);
      d = (j < 0) ? 8'hA5 : 8'(base + j);
      set_lane(n, (j == 0) || (j == 3), 1'b1, (eop_at > 0) && (j == eop_at - 1), d,
               (j == 0) ? tg : ~tg);
      if (j == 1) ireq[n] = 1'b0;
      if (j == rdy_drop) icore_rdy = 1'b0;
      if (j == fwd) check("revoke", 32'(ogrant), 32'd0);
      @(negedge iclk);
    end
    clear_lanes();
    @(negedge iclk);
    #1;
    check("count", mon_q.size(), fwd);
    for (int k = 0; k < fwd; k++) begin
      lerr = 2'b00;
      if (k == fwd - 1) begin
        if (eop_at == fwd && fwd < FL) lerr = 2'b01;
        else if (eop_at != fwd)        lerr = 2'b10;
      end
      exp = {k == 0, k == fwd - 1, lerr, 2'(n), tg, 8'(base + k)};
      got = '1;
      if (mon_q.size() > 0) got = mon_q.pop_front();
      check("word", 32'(got), 32'(exp));
    end
    mon_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] w;
    ireset = 1'b0; iclkena = 1'b1; icore_rdy = 1'b0; ireq = '0;
    isop = '0; ival = '0; ieop = '0; idat = '0; itag = '0;
    repeat (3) @(negedge iclk);
    check("rst_grant", 32'(ogrant), 32'd0);
    check("rst_ctrl", 32'({ocore_sop, ocore_val, ocore_eop, oerr}), 32'd0);
    check("rst_data", 32'({ocore_tag, ocore_dat}), 32'd0);
    ireset = 1'b1;

    // all four pending: served in order 0..3
    @(negedge iclk);
    ireq = 4'b1111; icore_rdy = 1'b1;
    run_frame(0, 8, 8, 0, 99, 8'h10, 4'h1);
    run_frame(1, 8, 8, 0, 99, 8'h20, 4'h2);
    run_frame(2, 8, 8, 0, 99, 8'h30, 4'h3);
    run_frame(3, 8, 8, 0, 99, 8'h40, 4'h4);

    // rr pointer to 3, then lone request 2, then 3 wraps before 0
    ireq = 4'b0100;
    run_frame(2, 8, 8, 0, 99, 8'h50, 4'h5);
    ireq = 4'b0100;
    run_frame(2, 8, 8, 2, 99, 8'h60, 4'h6);
    ireq = 4'b1001;
    run_frame(3, 8, 8, 0, 99, 8'h70, 4'h7);
    run_frame(0, 8, 8, 0, 99, 8'h80, 4'h8);

    // short frame from 1, then 2 is next
    ireq = 4'b0110;
    run_frame(1, 5, 5, 0, 99, 8'h90, 4'h9);
    run_frame(2, 8, 8, 0, 99, 8'hA0, 4'hA);

    // overlong frame from 0 is truncated at word 8
    ireq = 4'b0001;
    run_frame(0, 10, 0, 0, 99, 8'hB0, 4'hB);

    // encoder not ready holds off the grant; dropping it mid-frame has no effect
    icore_rdy = 1'b0; ireq = 4'b0001;
    repeat (5) @(negedge iclk);
    check("rdy_hold", 32'(ogrant), 32'd0);
    icore_rdy = 1'b1;
    @(negedge iclk);
    check("rdy_grant", 32'(ogrant), 32'd1);
    run_frame(0, 8, 8, 0, 2, 8'hC0, 4'hC);
    icore_rdy = 1'b1;

    // asynchronous reset in the middle of a frame from 2
    ireq = 4'b0100;
    wait_grant();
    check("grant_pre_rst", 32'(ogrant), 32'b0100);
    for (int j = 0; j < 3; j++) begin
      set_lane(2, j == 0, 1'b1, 1'b0, 8'(8'hD0 + j), 4'hD);
      @(negedge iclk);
    end
    check("val_pre_rst", 32'(ocore_val), 32'd1);
    #2 ireset = 1'b0;
    #1;
    check("arst_grant", 32'(ogrant), 32'd0);
    check("arst_ctrl", 32'({ocore_sop, ocore_val, ocore_eop, oerr}), 32'd0);
    check("arst_data", 32'({ocore_tag, ocore_dat}), 32'd0);
    clear_lanes();
    ireq = '0;
    mon_q.delete();
    @(negedge iclk);
    ireset = 1'b1;
    ireq = 4'b0100;
    run_frame(2, 8, 8, 0, 99, 8'hE0, 4'hE);

    // clock enable low stretches the short-frame error pulse
    ireq = 4'b0010;
    wait_grant();
    check("grant_ena", 32'(ogrant), 32'b0010);
    set_lane(1, 1'b1, 1'b1, 1'b1, 8'h5A, 4'h7);
    ireq = '0;
    @(negedge iclk);
    clear_lanes();
    check("pulse_first", 32'({ocore_eop, oerr}), 32'b101);
    iclkena = 1'b0;
    repeat (2) @(negedge iclk);
    check("pulse_hold", 32'(oerr), 32'b01);
    check("pulse_hold_vg", 32'({ocore_val, ogrant}), 32'b10000);
    iclkena = 1'b1;
    @(negedge iclk);
    #1;
    check("pulse_end", 32'(oerr), 32'd0);
    check("pulse_words", mon_q.size(), 1);
    w = '1;
    if (mon_q.size() > 0) w = mon_q.pop_front();
    check("pulse_word", 32'(w), 32'({1'b1, 1'b1, 2'b01, 2'd1, 4'h7, 8'h5A}));
    mon_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
